// File: rtl/lzd_pkg.sv
// Shared constants and elaboration-time helpers for the leading-zero detector.
package lzd_pkg;

  localparam int GROUP_DEF = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ng_of(input int swr, input int grp);
    return (swr + grp - 1) / grp;
  endfunction

endpackage

// File: rtl/lzd_pipe_if.sv
// Valid/ready bundle for lzd_pipe; Zero_o exists only with LZD_ZERO_FLAG_EN defined.
interface lzd_pipe_if #(
  parameter int SWR = 26,
  parameter int EWR = 5
);
  logic           valid_i;
  logic           ready_o;
  logic [SWR-1:0] Add_subt_result_i;
  logic           valid_o;
  logic           ready_i;
  logic [EWR-1:0] Shift_Value_o;
`ifdef LZD_ZERO_FLAG_EN
  logic           Zero_o;
`endif

  modport slave (
    input  valid_i, Add_subt_result_i, ready_i,
`ifdef LZD_ZERO_FLAG_EN
    output Zero_o,
`endif
    output ready_o, valid_o, Shift_Value_o
  );

  modport master (
    output valid_i, Add_subt_result_i, ready_i,
`ifdef LZD_ZERO_FLAG_EN
    input  Zero_o,
`endif
    input  ready_o, valid_o, Shift_Value_o
  );
endinterface

// File: rtl/lzd_group_enc.sv
// One GROUP-bit segment -> leading-zero count from its MSB plus nonzero flag.
// Purely combinational; count is 0 when the segment is all zeros.
module lzd_group_enc
  import lzd_pkg::*;
#(
  parameter int GROUP = GROUP_DEF
) (
  input  logic [GROUP-1:0]        seg_i,
  output logic [clog2(GROUP)-1:0] cnt_o,
  output logic                    nz_o
);
  localparam int LW = clog2(GROUP);

  // Scan upward so the highest set bit is the last one written.
  always_comb begin
    cnt_o = '0;
    nz_o  = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      if (seg_i[i]) begin
        cnt_o = LW'(GROUP - 1 - i);
        nz_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lzd_pipe.sv
// 2-stage leading-zero detector (segment encode, then select/saturate); LZD_ZERO_FLAG_EN adds Zero_o.
// Latency 2 cycles, one beat/cycle; each stage holds while downstream stalls, ready_o drops when full.
module lzd_pipe
  import lzd_pkg::*;
#(
  parameter int SWR   = 26,
  parameter int EWR   = 5,
  parameter int GROUP = GROUP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  lzd_pipe_if.slave  io
);
  localparam int NG = ng_of(SWR, GROUP);
  localparam int LW = clog2(GROUP);
  localparam int PW = NG * GROUP;

  if (SWR < 8 || SWR > 128) begin : g_bad_swr
    $error("lzd_pipe: SWR must be within 8..128");
  end
  if ((2 ** EWR) <= SWR) begin : g_bad_ewr
    $error("lzd_pipe: EWR too narrow to hold a count of SWR");
  end
  if (GROUP != 4 && GROUP != 8 && GROUP != 16) begin : g_bad_group
    $error("lzd_pipe: GROUP must be 4, 8 or 16");
  end

  logic [PW-1:0]          padded;
  logic [NG-1:0][LW-1:0]  seg_cnt;
  logic [NG-1:0]          seg_nz;

  logic                   s1_vld_q, s1_vld_d;
  logic [NG-1:0][LW-1:0]  s1_cnt_q, s1_cnt_d;
  logic [NG-1:0]          s1_nz_q,  s1_nz_d;
  logic                   s2_vld_q, s2_vld_d;
  logic [EWR-1:0]         shift_q,  shift_d;
`ifdef LZD_ZERO_FLAG_EN
  logic                   zero_q,   zero_d;
`endif

  logic                   s1_adv;
  logic                   s2_adv;
  logic                   in_xfer;
  int                     sel;

  // Segment 0 is the most significant; a short last segment is padded with zeros below bit 0.
  always_comb begin
    padded                = '0;
    padded[PW-1 -: SWR]   = io.Add_subt_result_i;
  end

  for (genvar g = 0; g < NG; g++) begin : g_seg
    lzd_group_enc #(.GROUP(GROUP)) u_enc (
      .seg_i (padded[PW-1-g*GROUP -: GROUP]),
      .cnt_o (seg_cnt[g]),
      .nz_o  (seg_nz[g])
    );
  end

  assign s2_adv     = s2_vld_q && io.ready_i;
  assign s1_adv     = s1_vld_q && (!s2_vld_q || io.ready_i);
  assign io.ready_o = !s1_vld_q || s1_adv;
  assign in_xfer    = io.valid_i && io.ready_o;

  // No nonzero segment leaves sel at PW, which saturates to SWR.
  always_comb begin
    sel = PW;
    for (int g = NG - 1; g >= 0; g--) begin
      if (s1_nz_q[g]) sel = g * GROUP + int'(s1_cnt_q[g]);
    end
    if (sel > SWR) sel = SWR;
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_cnt_d = s1_cnt_q;
    s1_nz_d  = s1_nz_q;
    s2_vld_d = s2_vld_q;
    shift_d  = shift_q;
`ifdef LZD_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    if (in_xfer) begin
      s1_vld_d = 1'b1;
      s1_cnt_d = seg_cnt;
      s1_nz_d  = seg_nz;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end
    if (s1_adv) begin
      s2_vld_d = 1'b1;
      shift_d  = EWR'(sel);
`ifdef LZD_ZERO_FLAG_EN
      zero_d   = (sel == SWR);
`endif
    end else if (s2_adv) begin
      s2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_cnt_q <= '0;
      s1_nz_q  <= '0;
      s2_vld_q <= 1'b0;
      shift_q  <= '0;
`ifdef LZD_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_cnt_q <= s1_cnt_d;
      s1_nz_q  <= s1_nz_d;
      s2_vld_q <= s2_vld_d;
      shift_q  <= shift_d;
`ifdef LZD_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign io.valid_o       = s2_vld_q;
  assign io.Shift_Value_o = shift_q;
`ifdef LZD_ZERO_FLAG_EN
  assign io.Zero_o        = zero_q;
`endif

endmodule

// File: tb/tb_lzd_pipe.sv
// Bench for lzd_pipe: leading-zero reference model with scoreboard, stall/reset/back-to-back phases,
// plus a second SWR=55 instance for the partial-segment path. Honours LZD_ZERO_FLAG_EN.
module tb_lzd_pipe;
  localparam int SWR  = 26;
  localparam int EWR  = 5;
  localparam int SWR2 = 55;
  localparam int EWR2 = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lzd_pipe_if #(.SWR(SWR),  .EWR(EWR))  bus  ();
  lzd_pipe_if #(.SWR(SWR2), .EWR(EWR2)) bus2 ();

  lzd_pipe #(.SWR(SWR),  .EWR(EWR),  .GROUP(8)) u_dut  (.clk(clk), .rst(rst), .io(bus));
  lzd_pipe #(.SWR(SWR2), .EWR(EWR2), .GROUP(8)) u_dut2 (.clk(clk), .rst(rst), .io(bus2));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit lat_mode = 1'b0;

  typedef struct {
    int cnt;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc++;

  // Reference: count zeros from bit w-1 downward; all zeros gives w.
  function automatic int lzc(input logic [127:0] v, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) return w - 1 - i;
    end
    return w;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [SWR-1:0] rnd26();
    logic [31:0] r;
    r = $urandom & 32'h03FF_FFFF;
    r = r >> $urandom_range(0, SWR);
    return r[SWR-1:0];
  endfunction

  function automatic logic [SWR2-1:0] rnd55();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r = r & ((64'd1 << SWR2) - 64'd1);
    r = r >> $urandom_range(0, SWR2);
    return r[SWR2-1:0];
  endfunction

  // Scoreboard and hold checker for the SWR=26 instance.
  logic           prev_stall = 1'b0;
  logic [EWR-1:0] prev_sv    = '0;
  exp_t           e;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.valid_o, 1);
        chk("hold_shift", bus.Shift_Value_o, prev_sv);
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got result %0d, expected no result", bus.Shift_Value_o);
        end else begin
          e = exp_q.pop_front();
          chk("shift", bus.Shift_Value_o, e.cnt);
`ifdef LZD_ZERO_FLAG_EN
          chk("zero", bus.Zero_o, e.cnt == SWR);
`endif
          if (lat_mode) chk("latency", cyc - e.cyc, 2);
        end
      end
      if (bus.valid_i && bus.ready_o)
        exp_q.push_back('{cnt: lzc(128'(bus.Add_subt_result_i), SWR), cyc: cyc});
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_sv    = bus.Shift_Value_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [SWR-1:0] d, output int tries);
    bit done;
    bus.valid_i           = 1'b1;
    bus.Add_subt_result_i = d;
    tries = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (bus.ready_o) done = 1'b1;
      step();
      if (!done) begin
        tries++;
        if (tries > 50) begin
          n_cmp++;
          n_err++;
          $display("FAIL send_timeout: ready_o stayed 0, expected 1");
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic dir(input logic [SWR-1:0] d, input int exp, input string nm);
    int tries;
    int lat;
    bus.ready_i = 1'b1;
    send(d, tries);
    bus.valid_i = 1'b0;
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_lat"}, lat, 1);
    chk(nm, bus.Shift_Value_o, exp);
`ifdef LZD_ZERO_FLAG_EN
    chk({nm, "_zero"}, bus.Zero_o, exp == SWR);
`endif
    step();
  endtask

  task automatic dir2(input logic [SWR2-1:0] d, input int exp, input string nm);
    int lat;
    bus2.valid_i           = 1'b1;
    bus2.Add_subt_result_i = d;
    @(negedge clk);
    chk({nm, "_rdy"}, bus2.ready_o, 1);
    step();
    bus2.valid_i = 1'b0;
    lat = 99;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus2.valid_o) begin
        lat = i;
        break;
      end
    end
    chk({nm, "_lat"}, lat, 1);
    chk(nm, bus2.Shift_Value_o, exp);
`ifdef LZD_ZERO_FLAG_EN
    chk({nm, "_zero"}, bus2.Zero_o, exp == SWR2);
`endif
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tries;
    rst                    = 1'b1;
    bus.valid_i            = 1'b1;
    bus.Add_subt_result_i  = '1;
    bus.ready_i            = 1'b1;
    bus2.valid_i           = 1'b1;
    bus2.Add_subt_result_i = '1;
    bus2.ready_i           = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_valid_o", bus.valid_o, 0);
    chk("rst_shift", bus.Shift_Value_o, 0);
`ifdef LZD_ZERO_FLAG_EN
    chk("rst_zero", bus.Zero_o, 0);
`endif
    chk("rst_valid_o_55", bus2.valid_o, 0);
    step();
    rst          = 1'b0;
    bus.valid_i  = 1'b0;
    bus2.valid_i = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.ready_o, 1);
    step();

    chk("model_pin_msb", lzc(128'h200_0000, SWR), 0);
    chk("model_pin_pad", lzc(128'h1, SWR2), 54);

    dir(26'h200_0000, 0,  "msb");
    dir(26'h000_0001, 25, "lsb");
    dir(26'h000_0000, 26, "all_zero");
    dir(26'h004_0000, 7,  "bit18");
    dir(26'h3FF_FFFF, 0,  "all_ones");

    dir2(55'h8000_0000_0000, 7,  "w55_bit47");
    dir2(55'h1,              54, "w55_bit0");
    dir2(55'h0,              55, "w55_zero");
    dir2(55'h100_0000_0000,  14, "w55_bit40");
    for (int i = 0; i < 12; i++) begin
      logic [SWR2-1:0] d;
      d = rnd55();
      dir2(d, lzc(128'(d), SWR2), "w55_rand");
    end

    // Ten beats with the consumer stalled for cycles 3..6 of the phase.
    fork
      begin
        bus.ready_i = 1'b1;
        repeat (3) step();
        bus.ready_i = 1'b0;
        repeat (2) step();
        @(negedge clk);
        chk("stall_ready_o", bus.ready_o, 0);
        repeat (2) step();
        bus.ready_i = 1'b1;
      end
      begin
        for (int i = 0; i < 10; i++) send(rnd26(), tries);
        bus.valid_i = 1'b0;
      end
    join
    repeat (5) step();
    chk("stall_drained", exp_q.size(), 0);

    lat_mode = 1'b1;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(rnd26(), tries);
      chk("b2b_accept_wait", tries, 0);
    end
    bus.valid_i = 1'b0;
    repeat (4) step();
    lat_mode = 1'b0;
    chk("b2b_drained", exp_q.size(), 0);

    // Two beats in flight, then a one-cycle reset must discard both.
    bus.ready_i = 1'b0;
    send(26'h000_0100, tries);
    send(26'h010_0000, tries);
    bus.valid_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid_o", bus.valid_o, 0);
    chk("midrst_ready_o", bus.ready_o, 1);
    bus.ready_i = 1'b1;
    repeat (6) step();

    for (int c = 0; c < 400; c++) begin
      bit acc;
      if (!bus.valid_i && ($urandom_range(0, 3) != 0)) begin
        bus.valid_i           = 1'b1;
        bus.Add_subt_result_i = rnd26();
      end
      bus.ready_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.valid_i && bus.ready_o;
      step();
      if (acc) bus.valid_i = 1'b0;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (5) step();
    chk("soak_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lzd_pipe.md
LZD_PIPE -- requirements
Module: lzd_pipe

Interface
REQ-001 Parameter SWR, default 26: significand/result width searched for leading zeros, legal 8..128.
REQ-002 Parameter EWR, default 5: shift-count width; elaboration SHALL fail if 2**EWR <= SWR.
REQ-003 Parameter GROUP, default 8: bits per stage-1 segment, legal 4, 8 or 16.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 valid_i  input  1  Add_subt_result_i carries a beat.
REQ-007 ready_o  output  1  block accepts a beat this cycle.
REQ-008 Add_subt_result_i  input  SWR  adder result; bit SWR-1 is the MSB searched first.
REQ-009 valid_o  output  1  Shift_Value_o holds a result.
REQ-010 ready_i  input  1  downstream accepts the result this cycle.
REQ-011 Shift_Value_o  output  EWR  leading-zero count, i.e. left-shift amount for normalisation.
REQ-012 Zero_o  output  1  input beat was all zeros (present only with LZD_ZERO_FLAG_EN).

Function
REQ-013 A beat transfers on input when valid_i && ready_o, and on output when valid_o && ready_i.
REQ-014 Shift_Value_o SHALL equal the number of consecutive zero bits from bit SWR-1 downward; all-zero input yields exactly SWR.
REQ-015 Stage 1 SHALL split the input into NG = ceil(SWR/GROUP) segments from the MSB; a partial last segment is zero-padded below bit 0.
REQ-016 Stage 1 SHALL register per-segment local count (clog2(GROUP) bits) and per-segment nonzero flag.
REQ-017 Stage 2 SHALL select the most significant nonzero segment k and register count = k*GROUP + local_k, saturated to SWR.
REQ-018 Latency SHALL be exactly 2 cycles from input transfer to valid_o with ready_i held high; throughput one beat per cycle.
REQ-019 Each stage holds one beat; stage n advances when stage n+1 is empty or transfers out the same cycle.
REQ-020 ready_o = !s1_valid || s1_advance; no combinational path from valid_i to valid_o, nor from ready_i to Shift_Value_o.
REQ-021 With valid_o high and ready_i low, Shift_Value_o, Zero_o and valid_o SHALL hold stable; no beat is dropped or duplicated.
REQ-022 Simultaneous input and output transfer on a full pipe SHALL be accepted without a bubble.
REQ-023 Data registers of an empty stage are don't-care; only the valid bits gate behaviour.

Reset
REQ-024 While rst is high at a clock edge, all stage valid bits clear; valid_o=0, Shift_Value_o=0, Zero_o=0.
REQ-025 ready_o SHALL be 1 in the first cycle after rst deasserts.
REQ-026 rst mid-operation SHALL discard all in-flight beats; no result for them is ever presented.
REQ-027 Input beats presented during reset are not accepted.

Configuration
REQ-028 Macro LZD_ZERO_FLAG_EN defined: Zero_o port exists, registered alongside Shift_Value_o, high exactly when the count equals SWR.
REQ-029 Macro LZD_ZERO_FLAG_EN undefined: Zero_o port and its registers are absent; Shift_Value_o behaviour is unchanged.

Structure
REQ-030 Shared package lzd_pkg SHALL hold the GROUP default, an ng_of(SWR,GROUP) constant function and a clog2 function.
REQ-031 Sub-module lzd_group_enc (one GROUP-bit segment -> local count + nonzero flag, combinational) SHALL be instantiated NG times.
REQ-032 The top level SHALL contain only the stage registers, the segment selection/saturation logic and the handshake.

Verification
REQ-033 SWR=26, EWR=5, input 26'h2000000 -> Shift_Value_o=0 two cycles later; 26'h0000001 -> 25.
REQ-034 SWR=26, input 0 -> Shift_Value_o=26, Zero_o=1 (macro on); same stimulus with macro off compiles without Zero_o and gives 26.
REQ-035 SWR=55, EWR=6, GROUP=8, only bit 47 set -> 7; only bit 0 set -> 54 (partial segment path).
REQ-036 Stream of 10 random beats with ready_i low for cycles 3..6 -> ready_o low after 2 beats buffered, all 10 results in order, matching the reference model.
REQ-037 rst asserted for one cycle with 2 beats in flight -> valid_o=0 next cycle, neither beat ever appears at the output.
REQ-038 Back-to-back beats with ready_i constantly high -> one result per cycle, no bubbles.
